matrix_multiplier_8x8: RTL and testbench

- Computes the signed 8x8 matrix product P = H x D for the image-compression transform path, e.g. Haar or DCT basis times a pixel block.
- Operands stream in one element pair per cycle, row-major.
- The block multiplies with a single sequential MAC and streams the 64 result elements out row-major.
- It sits between the block buffer and the quantiser.

---
 rtl/matrix_multiplier_8x8_pkg.sv | 21 ++
 rtl/matrix_multiplier_8x8_if.sv | 23 ++
 rtl/matrix_multiplier_8x8_mac_unit.sv | 34 +++
 rtl/matrix_multiplier_8x8.sv | 105 ++++++++++
 tb/tb_matrix_multiplier_8x8.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/matrix_multiplier_8x8_pkg.sv
// Shared constants and types for the 8x8 signed matrix multiplier.
package matrix_multiplier_8x8_pkg;

    localparam int N     = 8;
    localparam int WIDTH = 16;
    localparam int ACC_W = 36;
    localparam int DIM_W = 3;
    localparam int IDX_W = 2 * DIM_W;
    localparam int CNT_W = 3 * DIM_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N * N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N * N * N - 1);
    localparam logic [DIM_W-1:0] K_LAST   = DIM_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE
    } state_e;

endpackage

// File: rtl/matrix_multiplier_8x8_if.sv
// Operand load strobe, result stream and status of the matrix multiplier.
interface matrix_multiplier_8x8_if;
    import matrix_multiplier_8x8_pkg::*;

    logic                    F;
    logic signed [WIDTH-1:0] H;
    logic signed [WIDTH-1:0] D;
    logic signed [ACC_W-1:0] P;
    logic                    P_valid;
    logic                    busy;
    logic                    done;

    modport master (
        output F, H, D,
        input  P, P_valid, busy, done
    );

    modport slave (
        input  F, H, D,
        output P, P_valid, busy, done
    );

endinterface

// File: rtl/matrix_multiplier_8x8_mac_unit.sv
// Signed multiply with registered accumulate; clr restarts the sum.
module mac_unit
    import matrix_multiplier_8x8_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;

    assign prod = a * b;

    always_comb begin
        sum   = (clr ? '0 : acc_q)
              + {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
        acc_d = en ? sum : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_multiplier_8x8.sv
// Streams in H and D row-major, then emits P = H x D row-major
// using one sequential MAC.
module matrix_multiplier_8x8
    import matrix_multiplier_8x8_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    matrix_multiplier_8x8_if.slave bus
);

    state_e state_q, state_d;

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] p_q, p_d;
    logic                    p_valid_q, p_valid_d;
    logic                    done_q, done_d;

    logic signed [WIDTH-1:0] hm_q [N*N];
    logic signed [WIDTH-1:0] dm_q [N*N];

    logic                    wr_en;
    logic                    mac_en;
    logic signed [ACC_W-1:0] sum;
    logic [DIM_W-1:0]        i, j, k;

    assign k = cnt_q[DIM_W-1:0];
    assign j = cnt_q[2*DIM_W-1:DIM_W];
    assign i = cnt_q[3*DIM_W-1:2*DIM_W];

    // H walks along row i, D walks down column j.
    mac_unit u_mac (
        .clk (clk),
        .rst (rst),
        .en  (mac_en),
        .clr (k == '0),
        .a   (hm_q[{i, k}]),
        .b   (dm_q[{k, j}]),
        .sum (sum)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        p_valid_d = 1'b0;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        mac_en    = 1'b0;
        unique case (state_q)
            IDLE, LOAD: begin
                if (bus.F) begin
                    wr_en   = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == IDX_LAST) ? COMPUTE : LOAD;
                end
            end
            COMPUTE: begin
                mac_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (k == K_LAST) begin
                    p_d       = sum;
                    p_valid_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            hm_q[idx_q] <= bus.H;
            dm_q[idx_q] <= bus.D;
        end
    end

    assign bus.P       = p_q;
    assign bus.P_valid = p_valid_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q == COMPUTE);

endmodule

// File: tb/tb_matrix_multiplier_8x8.sv
// Directed bench for matrix_multiplier_8x8 with a queue scoreboard.
module tb_matrix_multiplier_8x8;
    import matrix_multiplier_8x8_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    matrix_multiplier_8x8_if mif ();

    matrix_multiplier_8x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int hmat [64];
    int dmat [64];
    logic signed [ACC_W-1:0] exp_q [$];

    task automatic check(string tag, logic signed [63:0] obs,
                         logic signed [63:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_expected();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                longint s;
                s = 0;
                for (int m = 0; m < 8; m++)
                    s += longint'(hmat[r*8+m]) * longint'(dmat[m*8+c]);
                exp_q.push_back(s[ACC_W-1:0]);
            end
        end
    endtask

    task automatic load(bit gaps);
        logic [31:0] hv, dv;
        for (int idx = 0; idx < 64; idx++) begin
            hv = hmat[idx];
            dv = dmat[idx];
            mif.F = 1'b1;
            mif.H = hv[WIDTH-1:0];
            mif.D = dv[WIDTH-1:0];
            @(negedge clk);
            if (gaps) begin
                mif.F = 1'b0;
                mif.H = WIDTH'($urandom);
                mif.D = WIDTH'($urandom);
                @(negedge clk);
            end
        end
        mif.F = 1'b0;
        push_expected();
    endtask

    task automatic drain(string tag, bit garbage, int stop_after,
                         output int first_t);
        int got;
        int target;
        got     = 0;
        first_t = -1;
        target  = (stop_after == 0) ? 64 : stop_after;
        for (int t = 1; t <= 600 && got < target; t++) begin
            if (garbage) begin
                mif.F = 1'b1;
                mif.H = WIDTH'($urandom);
                mif.D = WIDTH'($urandom);
            end
            @(negedge clk);
            if (mif.P_valid) begin
                got++;
                if (first_t < 0) first_t = t;
                if (exp_q.size() == 0) begin
                    check({tag, "_queue_empty"}, 64'(got), 64'(0));
                end else begin
                    check({tag, "_P"}, mif.P, exp_q.pop_front());
                end
                check({tag, "_done"}, 64'(mif.done), 64'(got == 64));
            end
        end
        mif.F = 1'b0;
        check({tag, "_pulse_count"}, 64'(got), 64'(target));
    endtask

    task automatic fill_identity(int diag);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                hmat[r*8+c] = (r == c) ? diag : 0;
                dmat[r*8+c] = r * 8 + c;
            end
    endtask

    task automatic fill_const(int hv, int dv);
        for (int n = 0; n < 64; n++) begin
            hmat[n] = hv;
            dmat[n] = dv;
        end
    endtask

    initial begin
        int ft;
        int stray;

        rst   = 1'b1;
        mif.F = 1'b0;
        mif.H = '0;
        mif.D = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_P", mif.P, 64'(0));
        check("rst_P_valid", 64'(mif.P_valid), 64'(0));
        check("rst_busy", 64'(mif.busy), 64'(0));
        check("rst_done", 64'(mif.done), 64'(0));

        // identity
        fill_identity(1);
        load(1'b0);
        check("id_busy", 64'(mif.busy), 64'(1));
        drain("id", 1'b0, 0, ft);
        check("id_latency", 64'(ft), 64'(8));
        check("id_busy_after", 64'(mif.busy), 64'(0));

        // constants with load gaps
        fill_const(1, 2);
        load(1'b1);
        drain("const", 1'b0, 0, ft);

        // signed extremes
        fill_const(-32768, -32768);
        load(1'b0);
        drain("min_min", 1'b0, 0, ft);
        fill_const(-32768, 32767);
        load(1'b0);
        drain("min_max", 1'b0, 0, ft);

        // negative identity
        fill_const(0, 32767);
        for (int n = 0; n < 8; n++) hmat[n*9] = -1;
        load(1'b0);
        drain("neg_id", 1'b0, 0, ft);

        // reset mid-compute
        fill_identity(1);
        load(1'b0);
        drain("pre_rst", 1'b0, 10, ft);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_P", mif.P, 64'(0));
        check("mid_rst_P_valid", 64'(mif.P_valid), 64'(0));
        check("mid_rst_busy", 64'(mif.busy), 64'(0));
        check("mid_rst_done", 64'(mif.done), 64'(0));
        stray = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (mif.P_valid || mif.done) stray++;
        end
        check("mid_rst_stray_pulses", 64'(stray), 64'(0));
        load(1'b0);
        drain("post_rst_id", 1'b0, 0, ft);

        // F toggling with garbage during compute
        for (int n = 0; n < 64; n++) begin
            hmat[n] = int'($urandom_range(65535)) - 32768;
            dmat[n] = int'($urandom_range(65535)) - 32768;
        end
        load(1'b0);
        drain("f_in_compute", 1'b1, 0, ft);
        fill_identity(1);
        load(1'b0);
        drain("reload_id", 1'b0, 0, ft);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
